// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry look-ahead adder:
// FSM state encoding and the nibble width handled per cycle.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/cla.sv
// 4-bit carry look-ahead adder: all carries formed in parallel from
// per-bit generate/propagate terms.
module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit adder that reuses one 4-bit CLA, one nibble per cycle LSB first.
// Define CLA_SEQ_OVF_EN to add the registered signed-overflow output Ovf.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef CLA_SEQ_OVF_EN
   ,output logic             Ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic             carry_p1;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [WIDTH-1:0] sum_p1;
    logic             cout_p1;
    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic             accept;
    logic             last;

    assign accept    = (state_q == IDLE) && in_valid;
    assign last      = (state_q == BUSY) && (idx_q == LAST_IDX);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Sum       = sum_p1;
    assign Cout      = cout_p1;

    cla u_cla (
        .a    (a_p0[idx_q*NIBBLE_W +: NIBBLE_W]),
        .b    (b_p0[idx_q*NIBBLE_W +: NIBBLE_W]),
        .cin  (carry_p1),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // p0: operand capture; the source may change A/B freely after this edge
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0 <= A;
            b_p0 <= B;
        end
    end

    // p1: one nibble per BUSY edge, carry rippled through carry_p1
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            carry_p1 <= 1'b0;
            sum_p1   <= '0;
            cout_p1  <= 1'b0;
        end else if (accept) begin
            idx_q    <= '0;
            carry_p1 <= Cin;
        end else if (state_q == BUSY) begin
            sum_p1[idx_q*NIBBLE_W +: NIBBLE_W] <= nib_sum;
            carry_p1 <= nib_cout;
            idx_q    <= idx_q + 1'b1;
            if (last) begin
                cout_p1 <= nib_cout;
            end
        end
    end

`ifdef CLA_SEQ_OVF_EN
    logic ovf_p1;

    assign Ovf = ovf_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_p1 <= 1'b0;
        end else if (last) begin
            ovf_p1 <= (a_p0[WIDTH-1] == b_p0[WIDTH-1]) && (nib_sum[3] != a_p0[WIDTH-1]);
        end
    end
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed and randomized-stall bench for cla_seq_adder (WIDTH=16).
module tb_cla_seq_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        Cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] Sum;
    logic        Cout;
`ifdef CLA_SEQ_OVF_EN
    logic        Ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout)
`ifdef CLA_SEQ_OVF_EN
       ,.Ovf       (Ovf)
`endif
    );

    // Called at #1 after an edge with the DUT idle; returns at #1 after the
    // edge on which out_valid rose (or after a 20-edge bound).
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, output int lat);
        A = a; B = b; Cin = cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = 16'hDEAD; B = 16'hBEEF; Cin = 1'b1;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, in_ready, Cout, Sum} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL reset: ov/ir/cout/sum=%b/%b/%b/%h required 0/1/0/0000",
                     out_valid, in_ready, Cout, Sum);
        end
`ifdef CLA_SEQ_OVF_EN
        n_cmp++;
        if (Ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovf: got %b required 0", Ovf);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_carry_ripple();
        int lat;
        do_op(16'hFFFF, 16'h0001, 1'b0, lat);
        n_cmp++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL ripple_latency: got %0d edges required 4", lat);
        end
        n_cmp++;
        if ({Cout, Sum} !== 17'h1_0000) begin
            n_err++;
            $display("FAIL ripple_sum: got %b/%h required 1/0000", Cout, Sum);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ripple_ready_in_done: in_ready=%b required 0", in_ready);
        end
        release_result();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL ripple_release: ov/ir=%b%b required 01", out_valid, in_ready);
        end
    endtask

    task automatic test_carry_in();
        int lat;
        do_op(16'h1234, 16'h4321, 1'b1, lat);
        n_cmp++;
        if ({Cout, Sum} !== {1'b0, 16'h5556} || lat !== 4) begin
            n_err++;
            $display("FAIL carry_in: got %b/%h lat %0d required 0/5556 lat 4", Cout, Sum, lat);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        do_op(16'h0F0F, 16'h00F1, 1'b0, lat);
        n_cmp++;
        if ({Cout, Sum} !== {1'b0, 16'h1000}) begin
            n_err++;
            $display("FAIL bp_result: got %b/%h required 0/1000", Cout, Sum);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            A = 16'hFFFF - 16'(i); B = 16'hFFFF; Cin = 1'b1;
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, in_ready, Cout, Sum} !== {1'b1, 1'b0, 1'b0, 16'h1000}) begin
                n_err++;
                $display("FAIL bp_hold%0d: ov/ir/cout/sum=%b/%b/%b/%h required 1/0/0/1000",
                         i, out_valid, in_ready, Cout, Sum);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready, Sum} !== {1'b0, 1'b1, 16'h1000}) begin
            n_err++;
            $display("FAIL bp_to_idle: ov/ir/sum=%b/%b/%h required 0/1/1000",
                     out_valid, in_ready, Sum);
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        A = 16'hAAAA; B = 16'h5555; Cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready, Cout, Sum} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL midop_reset: ov/ir/cout/sum=%b/%b/%b/%h required 0/1/0/0000",
                     out_valid, in_ready, Cout, Sum);
        end
        repeat (5) begin @(posedge clk); #1; end
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL midop_no_partial: ov/ir=%b%b required 01", out_valid, in_ready);
        end
        do_op(16'h0003, 16'h0004, 1'b0, lat);
        n_cmp++;
        if ({Cout, Sum} !== {1'b0, 16'h0007} || lat !== 4) begin
            n_err++;
            $display("FAIL midop_followup: got %b/%h lat %0d required 0/0007 lat 4", Cout, Sum, lat);
        end
        release_result();
    endtask

`ifdef CLA_SEQ_OVF_EN
    task automatic test_overflow();
        int lat;
        do_op(16'h7FFF, 16'h0001, 1'b0, lat);
        n_cmp++;
        if ({Ovf, Cout, Sum} !== {1'b1, 1'b0, 16'h8000}) begin
            n_err++;
            $display("FAIL ovf_pos: ovf/cout/sum=%b/%b/%h required 1/0/8000", Ovf, Cout, Sum);
        end
        release_result();
        do_op(16'h8000, 16'h8000, 1'b0, lat);
        n_cmp++;
        if ({Ovf, Cout, Sum} !== {1'b1, 1'b1, 16'h0000}) begin
            n_err++;
            $display("FAIL ovf_neg: ovf/cout/sum=%b/%b/%h required 1/1/0000", Ovf, Cout, Sum);
        end
        release_result();
        do_op(16'h0001, 16'hFFFF, 1'b0, lat);
        n_cmp++;
        if ({Ovf, Cout, Sum} !== {1'b0, 1'b1, 16'h0000}) begin
            n_err++;
            $display("FAIL ovf_none: ovf/cout/sum=%b/%b/%h required 0/1/0000", Ovf, Cout, Sum);
        end
        release_result();
    endtask
`endif

    task automatic test_back_to_back();
        int          lat;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [16:0] exp;
        for (int n = 0; n < 1000; n++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            exp = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
            do_op(a, b, cin, lat);
            n_cmp++;
            if ({Cout, Sum} !== exp || lat !== 4) begin
                n_err++;
                $display("FAIL sweep%0d: %h+%h+%b got %b/%h lat %0d required %b/%h lat 4",
                         n, a, b, cin, Cout, Sum, lat, exp[16], exp[15:0]);
                break;
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_carry_in();
        test_backpressure();
        test_reset_midop();
`ifdef CLA_SEQ_OVF_EN
        test_overflow();
`endif
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Multi-cycle WIDTH-bit adder built on the existing 4-bit carry look-ahead adder (`cla`).
- Adds one nibble per cycle, LSB first, and ripples the carry through a register between nibbles.
- Sits downstream of the operand source. It consumes `cla` Sum/Cout each cycle and presents a registered WIDTH-bit result over a valid/ready handshake.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived localparam; number of add cycles.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- Sum  output  WIDTH  registered sum.
- Cout  output  1  registered carry out of the MSB nibble.
- Ovf  output  1  signed overflow; present only with CLA_SEQ_OVF_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE, nibble index = 0, carry register = 0.
  - Sum = 0, Cout = 0, Ovf = 0.
  - out_valid = 0, in_ready = 1.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid=1 at an edge: capture A, B, Cin; set index = 0; go to BUSY.
- BUSY:
  - in_ready = 0.
  - The `cla` instance is fed A_reg[4*idx+3:4*idx], B_reg nibble and the carry register.
  - At each edge: write the `cla` Sum into Sum_reg nibble idx; load the carry register from the `cla` Cout; idx++.
  - At idx = NIBBLES-1: after writing, load Cout from the `cla` Cout and go to DONE.
- DONE:
  - out_valid = 1. Sum, Cout and Ovf are held stable.
  - On out_ready=1 at an edge: go to IDLE.
  - in_valid is ignored in DONE; there is no same-cycle accept.
- Latency: out_valid rises exactly NIBBLES edges after the accept edge (4 for WIDTH=16).
- Minimum issue period: NIBBLES+2 cycles.
- in_ready and out_valid are never both 1.
- Sum holds its last value after leaving DONE until the next nibble write. It is valid only while out_valid=1.
- Arithmetic: {Cout, Sum} = A + B + Cin, modulo 2^(WIDTH+1); unsigned.
- A and B may change freely after acceptance; only the captured copies are used.
- Reset mid-operation (BUSY or DONE) aborts the operation. Next cycle: IDLE with all outputs at reset values, and no partial result is emitted.
- rst has priority over in_valid and out_ready in the same cycle.
- WIDTH=4: a single BUSY cycle.

Optional Feature:
- Macro: CLA_SEQ_OVF_EN.
- Defined:
  - Ovf port exists.
  - In the final BUSY cycle, Ovf is registered as (A_reg MSB == B_reg MSB) && (Sum MSB != A_reg MSB).
  - Ovf is valid with out_valid and is reset to 0.
- Undefined: the Ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cla_pkg:
  - state encoding constants: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - NIBBLE_W = 4.
- Sub-module: the existing `cla` 4-bit carry look-ahead adder, instantiated once.
- No other sub-modules.

Test Plan:
- Carry ripple across all nibbles: A=16'hFFFF, B=16'h0001, Cin=0 -> Sum=16'h0000, Cout=1; out_valid asserts exactly 4 edges after accept.
- Carry-in path: A=16'h1234, B=16'h4321, Cin=1 -> Sum=16'h5556, Cout=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands.
  - Required: Sum and Cout stay stable; in_ready=0; new operands are not captured; IDLE follows the first out_ready=1 edge.
- Reset mid-op:
  - Stimulus: assert rst for 1 cycle when idx=2 of A=16'hAAAA, B=16'h5555.
  - Required: next cycle out_valid=0, Sum=0, Cout=0, in_ready=1; a subsequent op 16'h0003+16'h0004 returns 16'h0007.
- Overflow (CLA_SEQ_OVF_EN):
  - 16'h7FFF+16'h0001 -> Ovf=1, Cout=0.
  - 16'h8000+16'h8000 -> Sum=0, Cout=1, Ovf=1.
  - 16'h0001+16'hFFFF -> Ovf=0.
- Self-check sweep: 1000 random A/B/Cin issued back-to-back with random out_ready stalls. Required for every result: {Cout,Sum} === A+B+Cin; print FAILED and $finish on the first mismatch.
